// File: rtl/eth_rmii_pkg.sv
// Shared types and constants for the RMII receive path.
package eth_rmii_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_DATA,
        RX_DRAIN
    } rx_state_t;

    localparam logic [1:0]  DIBIT_PRE     = 2'b01;
    localparam logic [1:0]  DIBIT_SFD     = 2'b11;
    localparam int unsigned DEF_MAX_BYTES = 1536;

endpackage

// File: rtl/rmii_rx_align_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/rmii_rx_align.sv
// RMII receive front end: preamble/SFD detection, LSB-first byte assembly,
// frame error tracking and saturating good/drop frame counters.
module rmii_rx_align
    import eth_rmii_pkg::*;
#(
    parameter int unsigned MIN_PREAMBLE = 3,
    parameter int unsigned MAX_BYTES    = DEF_MAX_BYTES,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             loopback,
    input  logic [1:0]       rmii_rxd,
    input  logic             rmii_crs_dv,
    input  logic             rmii_rx_er,
    input  logic [1:0]       lb_txd,
    input  logic             lb_tx_en,
    output logic             mii_rx_frame_o,
    output logic [7:0]       mii_rx_data_o,
    output logic             mii_rx_byte_received_o,
    output logic             mii_rx_error_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned BC_W = $clog2(MAX_BYTES + 1);

    logic             dv_q, dv_d;
    logic [1:0]       rxd_q, rxd_d;
    logic             er_q, er_d;

    rx_state_t        state_q, state_d;
    logic [4:0]       pre_cnt_q, pre_cnt_d;
    logic [1:0]       dib_idx_q, dib_idx_d;
    logic [5:0]       sh_q, sh_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             strobe_q, strobe_d;
    logic             frame_q, frame_d;
    logic             err_q, err_d;
    logic             frame_inc_q, frame_inc_d;
    logic             drop_inc_q, drop_inc_d;

    // PHY receive error has no meaning on the looped-back transmit path.
    always_comb begin
        dv_d  = loopback ? lb_tx_en : rmii_crs_dv;
        rxd_d = loopback ? lb_txd   : rmii_rxd;
        er_d  = loopback ? 1'b0     : rmii_rx_er;
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        dib_idx_d   = dib_idx_q;
        sh_d        = sh_q;
        byte_cnt_d  = byte_cnt_q;
        data_d      = data_q;
        strobe_d    = 1'b0;
        frame_d     = frame_q;
        err_d       = err_q;
        frame_inc_d = 1'b0;
        drop_inc_d  = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (dv_q && (rxd_q == DIBIT_PRE)) begin
                    state_d   = RX_PREAMBLE;
                    pre_cnt_d = 5'd1;
                end
            end
            RX_PREAMBLE: begin
                if (!dv_q) begin
                    state_d = RX_IDLE;
                end else if (rxd_q == DIBIT_PRE) begin
                    if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + 5'd1;
                end else if ((rxd_q == DIBIT_SFD) && ({27'd0, pre_cnt_q} >= MIN_PREAMBLE)) begin
                    state_d    = RX_DATA;
                    dib_idx_d  = '0;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                    frame_d    = 1'b1;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (dv_q) begin
                    sh_d      = {rxd_q, sh_q[5:2]};
                    dib_idx_d = dib_idx_q + 2'd1;
                    if (er_q) err_d = 1'b1;
                    if (dib_idx_q == 2'd3) begin
                        // The byte that would exceed the limit is never presented.
                        if (byte_cnt_q == BC_W'(MAX_BYTES)) begin
                            err_d   = 1'b1;
                            frame_d = 1'b0;
                            state_d = RX_DRAIN;
                        end else begin
                            data_d     = {rxd_q, sh_q};
                            strobe_d   = 1'b1;
                            byte_cnt_d = byte_cnt_q + BC_W'(1);
                        end
                    end
                end else begin
                    state_d = RX_IDLE;
                    frame_d = 1'b0;
                    if (dib_idx_q != 2'd0) begin
                        err_d      = 1'b1;
                        drop_inc_d = 1'b1;
                    end else if (err_q) begin
                        drop_inc_d = 1'b1;
                    end else begin
                        frame_inc_d = 1'b1;
                    end
                end
            end
            RX_DRAIN: begin
                if (!dv_q) begin
                    state_d    = RX_IDLE;
                    drop_inc_d = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            dv_q        <= 1'b0;
            rxd_q       <= '0;
            er_q        <= 1'b0;
            state_q     <= RX_IDLE;
            pre_cnt_q   <= '0;
            dib_idx_q   <= '0;
            sh_q        <= '0;
            byte_cnt_q  <= '0;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_inc_q <= 1'b0;
            drop_inc_q  <= 1'b0;
        end else begin
            dv_q        <= dv_d;
            rxd_q       <= rxd_d;
            er_q        <= er_d;
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            dib_idx_q   <= dib_idx_d;
            sh_q        <= sh_d;
            byte_cnt_q  <= byte_cnt_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            frame_inc_q <= frame_inc_d;
            drop_inc_q  <= drop_inc_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk (clk_50),
        .rst (rst),
        .inc (frame_inc_q),
        .q   (frame_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk (clk_50),
        .rst (rst),
        .inc (drop_inc_q),
        .q   (drop_cnt_o)
    );

    assign mii_rx_frame_o         = frame_q;
    assign mii_rx_data_o          = data_q;
    assign mii_rx_byte_received_o = strobe_q;
    assign mii_rx_error_o         = err_q;

endmodule

// File: tb/tb_rmii_rx_align.sv
// Directed/randomized bench for rmii_rx_align with a byte-level reference model.
module tb_rmii_rx_align;

    localparam int unsigned MAXB = 1536;
    localparam int unsigned CW   = 3;
    localparam int          CMAX = 7;

    logic          clk_50 = 1'b0;
    logic          rst;
    logic          loopback;
    logic [1:0]    rmii_rxd;
    logic          rmii_crs_dv;
    logic          rmii_rx_er;
    logic [1:0]    lb_txd;
    logic          lb_tx_en;
    logic          frame;
    logic [7:0]    data;
    logic          strobe;
    logic          err;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;

    always #10 clk_50 = ~clk_50;

    rmii_rx_align #(
        .MIN_PREAMBLE (3),
        .MAX_BYTES    (MAXB),
        .CNT_W        (CW)
    ) dut (
        .clk_50                 (clk_50),
        .rst                    (rst),
        .loopback               (loopback),
        .rmii_rxd               (rmii_rxd),
        .rmii_crs_dv            (rmii_crs_dv),
        .rmii_rx_er             (rmii_rx_er),
        .lb_txd                 (lb_txd),
        .lb_tx_en               (lb_tx_en),
        .mii_rx_frame_o         (frame),
        .mii_rx_data_o          (data),
        .mii_rx_byte_received_o (strobe),
        .mii_rx_error_o         (err),
        .frame_cnt_o            (frame_cnt),
        .drop_cnt_o             (drop_cnt)
    );

    int passed = 0;
    int total  = 0;
    int exp_frames = 0;
    int exp_drops  = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] payload[$];

    int  cyc = 0;
    int  last_strobe = -100;
    int  strobe_bad = 0;
    int  spacing_bad = 0;
    int  rises = 0;
    logic prev_frame = 1'b0;

    always @(negedge clk_50) begin
        cyc++;
        if (rst) begin
            prev_frame = 1'b0;
        end else begin
            if (strobe) begin
                got.push_back(data);
                if (!frame) strobe_bad++;
                if (cyc - last_strobe < 4) spacing_bad++;
                last_strobe = cyc;
            end
            if (frame && !prev_frame) rises++;
            prev_frame = frame;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic drive(input logic [1:0] d, input logic dv, input logic er);
        if (loopback) begin
            lb_txd      = d;
            lb_tx_en    = dv;
            rmii_rxd    = 2'($urandom);
            rmii_crs_dv = 1'($urandom);
            rmii_rx_er  = 1'($urandom);
        end else begin
            rmii_rxd    = d;
            rmii_crs_dv = dv;
            rmii_rx_er  = er;
            lb_txd      = 2'($urandom);
            lb_tx_en    = 1'($urandom);
        end
        @(negedge clk_50);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int j = 0; j < 4; j++) drive(b[2*j +: 2], 1'b1, 1'b0);
    endtask

    task automatic fill_random(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    endtask

    // Sends preamble, SFD, payload and optional trailing dibits, then checks
    // the delivered bytes, error level and counters against the byte-level model.
    task automatic send_frame(input string tag, input int extra, input int er_byte, input int er_dib);
        int n;
        int nexp;
        int mism;
        bit good;
        logic [7:0] b;
        n = payload.size();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        chk({tag, "_frame_before_sfd"}, {31'd0, frame}, 32'd0);
        for (int i = 0; i < n; i++) begin
            b = payload[i];
            for (int j = 0; j < 4; j++) begin
                drive(b[2*j +: 2], 1'b1, (i == er_byte) && (j == er_dib));
                if (i == 0 && j == 0) chk({tag, "_frame_rise"}, {31'd0, frame}, 32'd1);
                if (er_byte >= 0 && i == er_byte + 3 && j == 0)
                    chk({tag, "_err_held"}, {31'd0, err}, 32'd1);
                if (n > int'(MAXB) && i == int'(MAXB) && j == 3)
                    chk({tag, "_frame_before_over"}, {31'd0, frame}, 32'd1);
            end
        end
        for (int k = 0; k < extra; k++) begin
            drive(2'($urandom), 1'b1, 1'b0);
            if (n > int'(MAXB) && k == 0) chk({tag, "_frame_fall_over"}, {31'd0, frame}, 32'd0);
        end
        idle(6);

        nexp = (n > int'(MAXB)) ? int'(MAXB) : n;
        for (int i = 0; i < nexp; i++) exp_q.push_back(payload[i]);
        good = (extra % 4 == 0) && (er_byte < 0) && (n <= int'(MAXB));
        if (n > int'(MAXB)) good = 1'b0;
        if (good) begin
            if (exp_frames < CMAX) exp_frames++;
        end else begin
            if (exp_drops < CMAX) exp_drops++;
        end

        mism = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) mism++;
        chk({tag, "_byte_count"}, got.size(), exp_q.size());
        chk({tag, "_byte_mismatches"}, mism, 0);
        chk({tag, "_error"}, {31'd0, err}, {31'd0, !good});
        chk({tag, "_frame_low"}, {31'd0, frame}, 32'd0);
        chk({tag, "_frame_cnt"}, {29'd0, frame_cnt}, exp_frames);
        chk({tag, "_drop_cnt"}, {29'd0, drop_cnt}, exp_drops);
        got.delete();
        exp_q.delete();
        payload.delete();
    endtask

    initial begin
        int r0;
        rst = 1'b1;
        loopback = 1'b0;
        rmii_rxd = '0;
        rmii_crs_dv = 1'b0;
        rmii_rx_er = 1'b0;
        lb_txd = '0;
        lb_tx_en = 1'b0;
        repeat (3) @(negedge clk_50);
        rst = 1'b0;
        idle(2);

        chk("reset_frame", {31'd0, frame}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'd0);
        chk("reset_strobe", {31'd0, strobe}, 32'd0);
        chk("reset_error", {31'd0, err}, 32'd0);
        chk("reset_frame_cnt", {29'd0, frame_cnt}, 32'd0);
        chk("reset_drop_cnt", {29'd0, drop_cnt}, 32'd0);

        payload = '{8'h01, 8'h23, 8'h45, 8'h67};
        send_frame("directed4", 0, -1, 0);

        r0 = rises;
        drive(2'b01, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b0);
        drive(2'b11, 1'b1, 1'b0);
        idle(6);
        chk("short_pre_no_frame", rises, r0);
        chk("short_pre_no_bytes", got.size(), 0);
        chk("short_pre_frame_cnt", {29'd0, frame_cnt}, exp_frames);
        chk("short_pre_drop_cnt", {29'd0, drop_cnt}, exp_drops);

        fill_random(2);
        send_frame("partial", 2, -1, 0);

        fill_random(60);
        send_frame("rx_er", 0, 1, int'($urandom_range(0, 3)));

        fill_random(int'($urandom_range(1, 40)));
        send_frame("good_after_err", 0, -1, 0);

        fill_random(int'(MAXB) + 1);
        send_frame("overlength", 12, -1, 0);

        for (int f = 0; f < 6; f++) begin
            fill_random(int'($urandom_range(1, 40)));
            send_frame("rand_good", 0, -1, 0);
        end

        loopback = 1'b1;
        idle(4);
        fill_random(64);
        send_frame("loopback64", 0, -1, 0);

        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        fill_random(10);
        for (int i = 0; i < 9; i++) send_byte(payload[i]);
        drive(payload[9][1:0], 1'b1, 1'b0);
        drive(payload[9][3:2], 1'b1, 1'b0);
        chk("pre_rst_frame", {31'd0, frame}, 32'd1);
        chk("pre_rst_bytes", got.size(), 9);
        chk("strobe_inside_frame", strobe_bad, 0);
        chk("strobe_spacing", spacing_bad, 0);

        #3 rst = 1'b1;
        #1;
        chk("async_rst_frame", {31'd0, frame}, 32'd0);
        chk("async_rst_data", {24'd0, data}, 32'd0);
        chk("async_rst_strobe", {31'd0, strobe}, 32'd0);
        chk("async_rst_error", {31'd0, err}, 32'd0);
        chk("async_rst_frame_cnt", {29'd0, frame_cnt}, 32'd0);
        chk("async_rst_drop_cnt", {29'd0, drop_cnt}, 32'd0);
        @(negedge clk_50);
        @(negedge clk_50);
        rst = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rmii_rx_align.md
# rmii_rx_align

Receive-side RMII front end for the Ethernet MAC. Consumes 2-bit RMII dibits at 50 MHz (or the transmit dibits in loopback), detects preamble and SFD, assembles LSB-first bytes, and presents them to the framing receiver as a frame flag, a byte and a one-cycle byte strobe. Also detects alignment, PHY and overlength errors and keeps saturating frame and drop counters for software.

## Interface
- `MIN_PREAMBLE`, default 3: minimum count of consecutive `01` dibits required before the SFD dibit.
- `MAX_BYTES`, default 1536: maximum accepted bytes per frame, SFD excluded.
- `CNT_W`, default 16: width of the statistics counters.

- `clk_50`  in  1  RMII reference clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `loopback`  in  1  1 = take `lb_tx_en`/`lb_txd`; 0 = take PHY pins.
- `rmii_rxd`  in  2  PHY receive dibit.
- `rmii_crs_dv`  in  1  PHY data valid; treated as RX_DV, with no CRS toggling.
- `rmii_rx_er`  in  1  PHY receive error; forced to 0 in loopback.
- `lb_txd`  in  2  transmit dibit for loopback.
- `lb_tx_en`  in  1  transmit enable for loopback.
- `mii_rx_frame_o`  out  1  high while a frame is being delivered.
- `mii_rx_data_o`  out  8  assembled byte.
- `mii_rx_byte_received_o`  out  1  one-cycle strobe: `mii_rx_data_o` is valid.
- `mii_rx_error_o`  out  1  frame error flag.
- `frame_cnt_o`  out  CNT_W  count of good frames, saturating.
- `drop_cnt_o`  out  CNT_W  count of aborted or errored frames, saturating.

## Operation
- Input stage registers `{dv, rxd, er}` after the loopback mux. The FSM works only on this registered copy.
- FSM states: IDLE, PREAMBLE, DATA, DRAIN.
- **IDLE**
  - dv=1 and rxd=`01` → PREAMBLE with `pre_cnt`=1.
  - Any other value stays in IDLE; this covers the `00` dibits before the preamble.
- **PREAMBLE**
  - rxd=`01`: `pre_cnt`++, saturating at 31.
  - rxd=`11` and `pre_cnt` ≥ MIN_PREAMBLE: SFD found. Go to DATA, clear `dib_idx`, byte count and error flag, assert frame.
  - rxd=`11` with too short a preamble, any other rxd, or dv=0: go to IDLE, no count change.
- **DATA**, while dv=1
  - Shift `sh = {rxd, sh[7:2]}` (first dibit received = bits [1:0]).
  - `dib_idx`++ mod 4; at `dib_idx`=3, emit the byte and increment the byte count.
  - er=1: set the error flag.
  - Byte count would exceed MAX_BYTES: set the error flag, go to DRAIN, deassert frame.
- **DATA**, on dv=0
  - `dib_idx`=0 and no error: frame ends good, `frame_cnt`++.
  - `dib_idx`≠0: partial byte discarded, error flag set, `drop_cnt`++.
  - Error flag already set: `drop_cnt`++.
  - Go to IDLE and deassert frame in every case.
- **DRAIN**: wait for dv=0, then `drop_cnt`++ and go to IDLE.
- `mii_rx_error_o` is a level: set as above, held through frame end, cleared on the next SFD.
- Counters saturate at all-ones; no wrap.
- A `loopback` change mid-frame is not filtered. The frame in progress is corrupted and is handled by the normal alignment/error rules.

## Timing
- Reset values: frame 0, data 0x00, strobe 0, error 0, both counters 0, FSM IDLE.
- Reset is asynchronous and takes effect mid-frame with no partial-byte output.
- Latency: a dibit sampled by the input register at edge n is consumed by the FSM at edge n+1.
  - A byte's strobe and data register at the edge consuming its 4th dibit.
  - Strobe is high for exactly one cycle, at most once every 4 cycles.
- `mii_rx_frame_o` rises at the edge consuming the SFD and falls at the edge consuming dv=0 (or the overlength byte).
  - The final byte's strobe always precedes the fall, at least one cycle earlier.
- Counter updates are visible one cycle after the frame falls.
- SFD and first data dibit are back to back: no idle cycle is required between them.

## Structure
- Package `eth_rmii_pkg`:
  - `rx_state_t` enum.
  - `DIBIT_PRE` = 2'b01, `DIBIT_SFD` = 2'b11.
  - Default `MAX_BYTES`.
- One sub-module, `sat_counter #(W)` (inc, q), instantiated twice for the counters.

## Test plan
- 7×`0x55` then `0xD5`, then 4 bytes `0x01 0x23 0x45 0x67`, dv low → 4 strobes with those bytes, error 0, `frame_cnt`=1.
- Preamble of two `01` dibits, then `11` → no frame assertion, counters unchanged.
- Valid frame, dv drops after 2 dibits of byte 3 → 2 strobes, error=1, `drop_cnt`=1, `frame_cnt`=0.
- `rx_er` pulsed during byte 2 of a 60-byte frame → 60 strobes, error held high until frame falls, `drop_cnt`=1.
- 1537-byte frame → 1536 strobes, frame falls after byte 1536, DRAIN until dv low, `drop_cnt`=1.
- `loopback`=1 with PHY pins toggling randomly, 64-byte pattern driven on `lb_txd` → exact 64 bytes out; `rst` asserted at byte 10 of the next frame → all outputs 0 on the same cycle.
